// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the default bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    IDLE  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } rx_state_e;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit, with a selectable reset level.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability filter: two back-to-back capture stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a cycle counter, stop-bit check,
// and a single holding register on a valid/ready output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int HUNT_BITS    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int HUNT_LEN = HUNT_BITS * CLKS_PER_BIT;
  localparam int CNT_W    = $clog2(HUNT_LEN + 1);
  localparam int IDX_W    = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] HUNT_END = CNT_W'(HUNT_LEN - 1);
  localparam logic [CNT_W-1:0] MID_END  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  rx_state_e                 state_r;
  rx_state_e                 state_s;
  logic                      rx_s;
  logic [CNT_W-1:0]          cnt_r;
  logic [IDX_W-1:0]          bit_idx_r;
  logic [UART_DATA_BITS-1:0] shift_r;
  logic [UART_DATA_BITS-1:0] data_r;
  logic                      valid_r;
  logic                      frame_err_r;
  logic                      overrun_r;
  logic                      load_s;
  logic                      ferr_s;
  logic                      ovr_s;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  wire hunt_done_s  = (state_r == HUNT)  && rx_s && (cnt_r == HUNT_END);
  wire start_tick_s = (state_r == START) && (cnt_r == MID_END);
  wire data_tick_s  = (state_r == DATA)  && (cnt_r == BIT_END);
  wire stop_tick_s  = (state_r == STOP)  && (cnt_r == BIT_END);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= HUNT;
    else       state_r <= state_s;
  end

  // FSM next-state logic; a bad stop bit re-enters HUNT to resynchronise on idle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      HUNT:    if (hunt_done_s) state_s = IDLE; else state_s = HUNT;
      IDLE:    if (!rx_s) state_s = START; else state_s = IDLE;
      START:   if (start_tick_s) state_s = rx_s ? IDLE : DATA; else state_s = START;
      DATA:    if (data_tick_s && (bit_idx_r == LAST_IDX)) state_s = STOP; else state_s = DATA;
      STOP:    if (stop_tick_s) state_s = rx_s ? IDLE : HUNT; else state_s = STOP;
      default: state_s = HUNT;
    endcase
  end

  // FSM outputs, all decided at the stop-bit sample.
  always_comb begin
    load_s = 1'b0;
    ferr_s = 1'b0;
    ovr_s  = 1'b0;
    case (state_r)
      STOP: begin
        if (stop_tick_s && rx_s) begin
          load_s = !valid_r || ready;
          ovr_s  = valid_r && !ready;
        end else begin
          load_s = 1'b0;
          ovr_s  = 1'b0;
        end
        if (stop_tick_s && !rx_s) ferr_s = 1'b1;
        else                      ferr_s = 1'b0;
      end
      default: begin
        load_s = 1'b0;
        ferr_s = 1'b0;
        ovr_s  = 1'b0;
      end
    endcase
  end

  // Shared cycle counter: idle-run length in HUNT, position within the bit elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else begin
      case (state_r)
        HUNT:       cnt_r <= (!rx_s || hunt_done_s) ? '0 : cnt_r + CNT_W'(1);
        IDLE:       cnt_r <= '0;
        START:      cnt_r <= start_tick_s ? '0 : cnt_r + CNT_W'(1);
        DATA, STOP: cnt_r <= (data_tick_s || stop_tick_s) ? '0 : cnt_r + CNT_W'(1);
        default:    cnt_r <= '0;
      endcase
    end
  end

  // LSB-first shift register and bit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_r   <= '0;
      bit_idx_r <= '0;
    end else if (start_tick_s) begin
      bit_idx_r <= '0;
    end else if (data_tick_s) begin
      shift_r   <= {rx_s, shift_r[UART_DATA_BITS-1:1]};
      bit_idx_r <= bit_idx_r + IDX_W'(1);
    end
  end

  // Holding register and registered one-cycle flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r      <= '0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= ferr_s;
      overrun_r   <= ovr_s;
      if (load_s) begin
        data_r  <= shift_r;
        valid_r <= 1'b1;
      end else if (valid_r && ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign data      = data_r;
  assign valid     = valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and random frames against uart_rx (16 clocks per bit); a negedge monitor
// collects accepted bytes and flag pulses, the main sequence compares them to expectations.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         long_pulse = 0;
  logic       prev_valid = 1'b0;
  logic       prev_fe = 1'b0;
  logic       prev_ov = 1'b0;
  time        rise_t = 0;
  time        fall_t = 0;
  time        last_start_t = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .HUNT_BITS(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Monitor: sample 1 ns after each falling edge, record handshakes and flag pulses.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      prev_valid = 1'b0;
      prev_fe    = 1'b0;
      prev_ov    = 1'b0;
    end else begin
      if (valid && !prev_valid) rise_t = $time - 1;
      if (!valid && prev_valid) fall_t = $time - 1;
      if (valid && ready) got_q.push_back(data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if ((frame_err && prev_fe) || (overrun && prev_ov)) long_pulse++;
      prev_valid = valid;
      prev_fe    = frame_err;
      prev_ov    = overrun;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pop_got();
    if (got_q.size() > 0) return got_q.pop_front();
    else return 8'hxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame on the pin: start 0, 8 data bits LSB first, stop bit, each CPB clocks long.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    @(negedge clk);
    last_start_t = $time;
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic expect_one(input string tag, input logic [7:0] b);
    check({tag, "_count"}, got_q.size(), 1);
    check(tag, pop_got(), b);
  endtask

  initial begin
    int         fe0;
    int         ov0;
    int         hits;
    logic [7:0] b;

    reset = 1'b1;
    rx    = 1'b1;
    ready = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    #2;
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);

    // Basic byte with latency: valid seen 155 clocks after the start edge on the pin.
    tick(20);
    send_byte(8'h55, 1'b1);
    tick(5);
    expect_one("b55", 8'h55);
    check("b55_latency", 32'(rise_t - last_start_t), 32'd1550);
    check("b55_valid_width", 32'(fall_t - rise_t), 32'd10);
    check("b55_no_fe", fe_cnt, 0);
    check("b55_no_ov", ov_cnt, 0);

    // Short low glitch is rejected at the start-bit check.
    tick(30);
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(30);
    check("glitch_no_byte", got_q.size(), 0);
    check("glitch_no_fe", fe_cnt, 0);
    send_byte(8'hC3, 1'b1);
    tick(5);
    expect_one("bC3", 8'hC3);

    // Framing error, then re-hunt for a full bit of idle.
    tick(20);
    fe0 = fe_cnt;
    send_byte(8'hA3, 1'b0);
    tick(1);
    check("fe_pulse", fe_cnt - fe0, 1);
    check("fe_no_byte", got_q.size(), 0);
    tick(6);
    send_byte(8'h3C, 1'b1);
    tick(200);
    hits = 0;
    while (got_q.size() > 0) if (pop_got() == 8'h3C) hits++;
    check("fe_short_idle_ignored", hits, 0);
    send_byte(8'h3C, 1'b1);
    tick(5);
    expect_one("b3C_after_hunt", 8'h3C);

    // Overrun: two frames while not ready; first held, second dropped.
    tick(20);
    ov0 = ov_cnt;
    @(negedge clk);
    ready = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tick(3);
    #2;
    check("ovr_valid", valid, 1'b1);
    check("ovr_data", data, 8'h11);
    check("ovr_pulse", ov_cnt - ov0, 1);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    #2;
    check("ovr_drained_valid", valid, 1'b0);
    check("ovr_data_held", data, 8'h11);
    expect_one("ovr_drain", 8'h11);

    // Consume the held byte in the very cycle the next one loads.
    tick(20);
    ov0 = ov_cnt;
    @(negedge clk);
    ready = 1'b0;
    send_byte(8'h66, 1'b1);
    tick(3);
    #2;
    check("same_cycle_held", data, 8'h66);
    fork
      send_byte(8'h77, 1'b1);
      begin
        @(negedge clk);
        repeat (154) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    tick(2);
    #2;
    check("same_cycle_valid", valid, 1'b1);
    check("same_cycle_data", data, 8'h77);
    check("same_cycle_no_ov", ov_cnt - ov0, 0);
    expect_one("same_cycle_consumed", 8'h66);
    @(negedge clk);
    ready = 1'b1;
    tick(2);
    expect_one("b77_drain", 8'h77);

    // Reset in the middle of data bit 4 of 0x00.
    tick(20);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    fork
      send_byte(8'h00, 1'b1);
      begin
        @(negedge clk);
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #2;
        check("midrst_data", data, 8'h00);
        check("midrst_valid", valid, 1'b0);
        check("midrst_frame_err", frame_err, 1'b0);
        check("midrst_overrun", overrun, 1'b0);
        @(negedge clk);
        reset = 1'b0;
      end
    join
    tick(40);
    check("midrst_no_byte", got_q.size(), 0);
    check("midrst_no_fe", fe_cnt - fe0, 0);
    check("midrst_no_ov", ov_cnt - ov0, 0);
    send_byte(8'h81, 1'b1);
    tick(5);
    expect_one("b81", 8'h81);

    // Random bytes with random (possibly zero) idle gaps; every good frame must arrive in order.
    tick(20);
    fe0 = fe_cnt;
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_byte(b, 1'b1);
      tick($urandom_range(0, 12));
    end
    tick(20);
    check("rand_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0) check("rand_byte", pop_got(), exp_q.pop_front());
    check("rand_no_fe", fe_cnt - fe0, 0);
    check("flag_pulse_width", long_pulse, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
